// File: rtl/rt_block_read_sequencer_if.sv
// Quadlet stream from the block read sequencer to the host packet builder.
// Valid/ready handshake; a beat transfers when out_valid && out_ready.
interface rt_block_read_sequencer_if;
  logic [31:0] out_data;
  logic [5:0]  out_index;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, out_index, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_index, out_last, out_valid, output out_ready);
endinterface

// File: rtl/rt_block_read_sequencer.sv
// Real-time block read sequencer: issues quadlet indices to the read-address
// translation stage, captures read data into a small FIFO, streams quadlets out.
module rt_block_read_sequencer #(
  parameter int NUM_MOTORS   = 4,
  parameter int NUM_ENCODERS = 4,
  parameter int RD_LATENCY   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] timestamp,
  output logic        busy,
  output logic        done,
  output logic [15:0] reg_raddr,
  output logic        blk_rt_rd,
  input  logic [31:0] reg_rdata,
  rt_block_read_sequencer_if.master os
);
  localparam int NQ = 4 + 2*NUM_MOTORS + 5*NUM_ENCODERS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0]  LAST_IDX = 7'(NQ - 1);
  localparam logic [CW:0] DEPTH_C  = (CW+1)'(FIFO_DEPTH);

  if (NQ > 64) begin : g_nq_chk
    $error("rt_block_read_sequencer: quadlet count exceeds 64");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_lat_chk
    $error("rt_block_read_sequencer: RD_LATENCY must be 1..3");
  end
  if (FIFO_DEPTH < RD_LATENCY + 1 || (1 << PW) != FIFO_DEPTH) begin : g_depth_chk
    $error("rt_block_read_sequencer: bad FIFO_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} st_e;
  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
  } ent_t;

  st_e                       st_q, st_d;
  logic [6:0]                issue_idx_q, issue_idx_d;
  logic [31:0]               ts_q, ts_d;
  logic [CW-1:0]             outst_q, outst_d;
  logic [CW-1:0]             fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ent_t [FIFO_DEPTH-1:0]     mem_q, mem_d;
  logic [RD_LATENCY:1]       vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY:1][5:0]  tag_pipe_q, tag_pipe_d;
  logic                      done_q, done_d;

  logic issue, fifo_push, fifo_pop, flush, out_vld;
  ent_t head, wr_ent;

  assign flush     = abort && (st_q != IDLE);
  assign out_vld   = (fifo_cnt_q != '0);
  assign fifo_push = vld_pipe_q[RD_LATENCY];
  assign fifo_pop  = out_vld && os.out_ready;
  assign head      = mem_q[rd_ptr_q];
  // Credits count both in-flight reads and captured entries, so a push never finds the FIFO full.
  assign issue     = (st_q == ISSUE) && !flush &&
                     (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);

  always_comb begin
    wr_ent.tag  = tag_pipe_q[RD_LATENCY];
    wr_ent.data = (tag_pipe_q[RD_LATENCY] == 6'd0) ? ts_q : reg_rdata;
  end

  always_comb begin
    st_d        = st_q;
    issue_idx_d = issue_idx_q;
    ts_d        = ts_q;
    done_d      = 1'b0;
    case (st_q)
      IDLE: if (start && !abort) begin
        ts_d        = timestamp;
        issue_idx_d = '0;
        st_d        = ISSUE;
      end
      ISSUE: if (issue) begin
        issue_idx_d = issue_idx_q + 7'd1;
        if (issue_idx_q == LAST_IDX) st_d = DRAIN;
      end
      DRAIN: if (fifo_pop && head.tag == LAST_IDX[5:0]) begin
        done_d = 1'b1;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (flush) begin
      st_d   = IDLE;
      done_d = 1'b0;
    end
  end

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    tag_pipe_d    = tag_pipe_q;
    vld_pipe_d[1] = issue;
    tag_pipe_d[1] = issue_idx_q[5:0];
    for (int i = 2; i <= RD_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
    if (flush) vld_pipe_d = '0;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q + PW'(fifo_push);
    rd_ptr_d   = rd_ptr_q + PW'(fifo_pop);
    fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    outst_d    = outst_q + CW'(issue) - CW'(fifo_push);
    if (fifo_push && !flush) mem_d[wr_ptr_q] = wr_ent;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      outst_d    = '0;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      st_q        <= IDLE;
      issue_idx_q <= '0;
      ts_q        <= '0;
      outst_q     <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '0;
      vld_pipe_q  <= '0;
      tag_pipe_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      issue_idx_q <= issue_idx_d;
      ts_q        <= ts_d;
      outst_q     <= outst_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      vld_pipe_q  <= vld_pipe_d;
      tag_pipe_q  <= tag_pipe_d;
      done_q      <= done_d;
    end
  end

  // While stalled in ISSUE the address holds at the next index to issue.
  always_comb begin
    case (st_q)
      ISSUE:   reg_raddr = {10'd0, issue_idx_q[5:0]};
      DRAIN:   reg_raddr = {10'd0, LAST_IDX[5:0]};
      default: reg_raddr = 16'd0;
    endcase
  end

  assign busy         = (st_q != IDLE);
  assign blk_rt_rd    = busy;
  assign done         = done_q;
  assign os.out_valid = out_vld;
  assign os.out_data  = out_vld ? head.data : 32'd0;
  assign os.out_index = out_vld ? head.tag  : 6'd0;
  assign os.out_last  = out_vld && (head.tag == LAST_IDX[5:0]);
endmodule

// File: tb/tb_rt_block_read_sequencer.sv
// Scoreboard bench: dut_a at default parameters, dut_b with 2 motors/2 encoders,
// read latency 3. Both share stimulus; a negedge monitor checks each stream.
module tb_rt_block_read_sequencer;
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic        sysclk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, rdy = 1'b0;
  logic [31:0] timestamp = 32'd0;
  logic        busy_a, done_a, blk_a, busy_b, done_b, blk_b;
  logic [15:0] raddr_a, raddr_b;
  logic [31:0] rdata_a, rb1, rb2, rb3;
  bit          tog = 1'b0;

  int   vectors = 0, fails = 0, busy_cyc_a = 0, hs_idx_a = -1;
  int   done_cnt [2];
  bit   done_pend [2];
  bit   hold_v [2];
  logic [38:0] hold [2];
  exp_t qa[$], qb[$];

  always #5 sysclk = ~sysclk;

  rt_block_read_sequencer_if ifa (), ifb ();
  assign ifa.out_ready = rdy;
  assign ifb.out_ready = rdy;

  rt_block_read_sequencer dut_a (
    .sysclk(sysclk), .reset(reset), .start(start), .abort(abort), .timestamp(timestamp),
    .busy(busy_a), .done(done_a), .reg_raddr(raddr_a), .blk_rt_rd(blk_a),
    .reg_rdata(rdata_a), .os(ifa));

  rt_block_read_sequencer #(.NUM_MOTORS(2), .NUM_ENCODERS(2), .RD_LATENCY(3), .FIFO_DEPTH(4)) dut_b (
    .sysclk(sysclk), .reset(reset), .start(start), .abort(abort), .timestamp(timestamp),
    .busy(busy_b), .done(done_b), .reg_raddr(raddr_b), .blk_rt_rd(blk_b),
    .reg_rdata(rb3), .os(ifb));

  // Register file model: data follows the address by the configured latency.
  always @(posedge sysclk) begin
    rdata_a <= 32'hA000_0000 | {16'd0, raddr_a};
    rb1     <= 32'hA000_0000 | {16'd0, raddr_b};
    rb2     <= rb1;
    rb3     <= rb2;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [31:0] dat, input logic [5:0] idx,
                     input logic lst, input logic dn);
    exp_t e;
    bit   empty;
    if (dn || done_pend[d]) chk($sformatf("done_%0d", d), 32'(dn), 32'(done_pend[d]));
    if (dn) done_cnt[d]++;
    done_pend[d] = 1'b0;
    if (hold_v[d] && v) chk($sformatf("stable_%0d", d), 32'({dat, idx, lst} == hold[d]), 32'd1);
    hold_v[d] = v && !rdy;
    hold[d]   = {dat, idx, lst};
    if (v && rdy) begin
      empty = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
      if (empty) begin
        vectors++; fails++;
        $display("FAIL extra_quadlet_%0d: got index %0d expected none", d, idx);
      end else begin
        if (d == 0) e = qa.pop_front(); else e = qb.pop_front();
        chk($sformatf("data_%0d[%0d]", d, e.idx), dat, e.data);
        chk($sformatf("index_%0d", d), 32'(idx), 32'(e.idx));
        chk($sformatf("last_%0d[%0d]", d, e.idx), 32'(lst), 32'(e.last));
        if (e.last) done_pend[d] = 1'b1;
        if (d == 0) hs_idx_a = int'(idx);
      end
    end
  endtask

  always @(negedge sysclk) begin
    if (reset) begin
      mon(0, ifa.out_valid, ifa.out_data, ifa.out_index, ifa.out_last, done_a);
      mon(1, ifb.out_valid, ifb.out_data, ifb.out_index, ifb.out_last, done_b);
      if (busy_a) busy_cyc_a++;
      if (dut_a.fifo_push && int'(dut_a.fifo_cnt_q) >= 4) begin
        fails++; $display("FAIL overflow_a: push with count %0d required below 4", dut_a.fifo_cnt_q);
      end
      if (dut_b.fifo_push && int'(dut_b.fifo_cnt_q) >= 4) begin
        fails++; $display("FAIL overflow_b: push with count %0d required below 4", dut_b.fifo_cnt_q);
      end
      if (int'(dut_b.outst_q) + int'(dut_b.fifo_cnt_q) > 4) begin
        fails++; $display("FAIL credits_b: %0d required at most 4", int'(dut_b.outst_q) + int'(dut_b.fifo_cnt_q));
      end
      if (raddr_a > 16'd31 || raddr_b > 16'd17) begin
        fails++; $display("FAIL raddr_range: got %0d/%0d required at most 31/17", raddr_a, raddr_b);
      end
    end
  end

  task automatic tick();
    @(posedge sysclk); #1;
    if (tog) rdy = ~rdy;
  endtask

  task automatic push_exp(input int d, input int nq, input logic [31:0] ts);
    exp_t e;
    for (int k = 0; k < nq; k++) begin
      e.data = (k == 0) ? ts : (32'hA000_0000 | 32'(k));
      e.idx  = 6'(k);
      e.last = (k == nq - 1);
      if (d == 0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  task automatic do_start(input logic [31:0] ts);
    push_exp(0, 32, ts);
    push_exp(1, 18, ts);
    hs_idx_a  = -1;
    timestamp = ts;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    timestamp = ts ^ 32'h5A5A_0F0F;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while ((done_cnt[0] < n || done_cnt[1] < n) && t < 2000) begin tick(); t++; end
    chk("done_timeout", 32'(t < 2000), 32'd1);
    tick(); tick();
    chk("queues_empty", 32'(qa.size() + qb.size()), 32'd0);
    chk("busy_a_after", 32'(busy_a), 32'd0);
    chk("busy_b_after", 32'(busy_b), 32'd0);
  endtask

  task automatic wait_idx_a(input int k);
    int t = 0;
    while (hs_idx_a < k && t < 500) begin tick(); t++; end
    chk("idx_wait_timeout", 32'(t < 500), 32'd1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy_a"},  32'(busy_a), 32'd0);
    chk({nm, "_busy_b"},  32'(busy_b), 32'd0);
    chk({nm, "_blk_a"},   32'(blk_a),  32'd0);
    chk({nm, "_done_a"},  32'(done_a), 32'd0);
    chk({nm, "_raddr_a"}, 32'(raddr_a), 32'd0);
    chk({nm, "_raddr_b"}, 32'(raddr_b), 32'd0);
    chk({nm, "_valid_a"}, 32'(ifa.out_valid), 32'd0);
    chk({nm, "_valid_b"}, 32'(ifb.out_valid), 32'd0);
    chk({nm, "_data_a"},  ifa.out_data, 32'd0);
    chk({nm, "_last_a"},  32'(ifa.out_last), 32'd0);
  endtask

  initial begin
    done_cnt[0] = 0; done_cnt[1] = 0;
    done_pend[0] = 1'b0; done_pend[1] = 1'b0;
    hold_v[0] = 1'b0; hold_v[1] = 1'b0;
    #12;
    chk_idle("reset");
    tick(); reset = 1'b1; tick();

    // Full-rate read, default latency.
    rdy = 1'b1;
    busy_cyc_a = 0;
    do_start(32'h1234_5678);
    wait_done(1);
    chk("busy_cycles_a", 32'(busy_cyc_a), 32'd34);

    // Toggling ready.
    tog = 1'b1;
    do_start(32'h0BAD_F00D);
    wait_done(2);
    tog = 1'b0;

    // Long stall: four credits issue, address freezes.
    rdy = 1'b0;
    do_start(32'h0000_BEEF);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_raddr_a_10", 32'(raddr_a), 32'd4);
    chk("stall_raddr_b_10", 32'(raddr_b), 32'd4);
    chk("stall_index_a", 32'(ifa.out_index), 32'd0);
    chk("stall_valid_a", 32'(ifa.out_valid), 32'd1);
    for (int i = 0; i < 9; i++) tick();
    chk("stall_raddr_a_20", 32'(raddr_a), 32'd4);
    chk("stall_raddr_b_20", 32'(raddr_b), 32'd4);
    rdy = 1'b1;
    wait_done(3);

    // Abort mid-read, then a fresh read.
    do_start(32'h0000_1111);
    wait_idx_a(10);
    rdy = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid_a", 32'(ifa.out_valid), 32'd0);
    chk("abort_valid_b", 32'(ifb.out_valid), 32'd0);
    chk("abort_busy_a",  32'(busy_a), 32'd0);
    chk("abort_busy_b",  32'(busy_b), 32'd0);
    chk("abort_blk_b",   32'(blk_b), 32'd0);
    qa.delete(); qb.delete();
    tick(); tick();
    chk("abort_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd6);
    rdy = 1'b1;
    do_start(32'hCAFE_BABE);
    wait_done(4);

    // Second start while busy is ignored.
    do_start(32'h55AA_55AA);
    wait_idx_a(5);
    timestamp = 32'hFFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5);

    // Asynchronous reset mid-read.
    do_start(32'h7777_0000);
    for (int i = 0; i < 8; i++) tick();
    #2 reset = 1'b0;
    #1 chk_idle("async_reset");
    qa.delete(); qb.delete();
    done_pend[0] = 1'b0; done_pend[1] = 1'b0;
    hold_v[0] = 1'b0; hold_v[1] = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
